// File: rtl/toggle_hs_pkg.sv
// Shared types and constants for the two-phase (toggle) handshake receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package toggle_hs_pkg;

    // Receiver FSM: IDLE waits for a request edge, HOLD owns a captured word.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Default depth of the request synchronizer chain.
    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/toggle_sync_edge.sv
// Synchronizes a toggle signal and turns each level change into a one-cycle edge strobe.
// Latency: tog_edge is high during the cycle after edge k+SYNC_STAGES-1 (k = first sampling edge).
// Backpressure: none; every level change produces exactly one strobe.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset; chain and history go to 0
//   tog      in   asynchronous toggle input (req_tog on the receiver, ack_tog on a sender)
//   tog_edge out  combinational strobe: synchronized level differs from last cycle's
module toggle_sync_edge
    import toggle_hs_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF  // must be >= 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tog,
    output logic tog_edge
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   req_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= '0;
            req_prev <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], tog};
            req_prev <= sync[SYNC_STAGES-1];
        end
    end

    // Compare the last synchronized level against its previous value; only
    // the final (settled) stage is used so metastability never reaches here.
    assign tog_edge = sync[SYNC_STAGES-1] ^ req_prev;

endmodule

// File: rtl/toggle_handshake_rx.sv
// Receiving end of a two-phase toggle handshake, handing words to a valid/ready consumer.
// Latency: out_valid/out_data/pulse/evt_cnt update at edge k+SYNC_STAGES; ack_tog toggles at the accepting edge.
// Backpressure: a word is held until out_ready; ack_tog is withheld meanwhile, toggles arriving then are dropped and flagged.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   req_tog      sender request toggle (one transfer per level change)
//   data_in      sender data, stable from req_tog change until ack_tog changes
//   ack_tog      acknowledge toggle, one change per accepted word
//   out_valid    captured word available
//   out_data     captured word
//   out_ready    consumer accept
//   pulse        one-cycle strobe per captured word
//   evt_cnt      captured-word count, wraps silently
//   err_overrun  sticky: a request edge arrived while a word was held
module toggle_handshake_rx
    import toggle_hs_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_tog,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_tog,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              pulse,
    output logic [CNT_W-1:0]  evt_cnt,
    output logic              err_overrun
);

    logic req_edge;

    toggle_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk      (clk),
        .rst      (rst),
        .tog      (req_tog),
        .tog_edge (req_edge)
    );

    state_t              state;
    state_t              state_nxt;
    logic                out_valid_nxt;
    logic [DATA_W-1:0]   out_data_nxt;
    logic                ack_tog_nxt;
    logic                pulse_nxt;
    logic [CNT_W-1:0]    evt_cnt_nxt;
    logic                err_overrun_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            out_data    <= '0;
            ack_tog     <= 1'b0;
            pulse       <= 1'b0;
            evt_cnt     <= '0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nxt;
            out_valid   <= out_valid_nxt;
            out_data    <= out_data_nxt;
            ack_tog     <= ack_tog_nxt;
            pulse       <= pulse_nxt;
            evt_cnt     <= evt_cnt_nxt;
            err_overrun <= err_overrun_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        out_valid_nxt   = out_valid;
        out_data_nxt    = out_data;
        ack_tog_nxt     = ack_tog;
        pulse_nxt       = 1'b0;
        evt_cnt_nxt     = evt_cnt;
        err_overrun_nxt = err_overrun;

        case (state)
            IDLE: begin
                if (req_edge) begin
                    out_data_nxt  = data_in;
                    out_valid_nxt = 1'b1;
                    pulse_nxt     = 1'b1;
                    evt_cnt_nxt   = evt_cnt + CNT_W'(1);
                    state_nxt     = HOLD;
                end
            end
            HOLD: begin
                // A new request while holding is dropped but remembered; the
                // held word still completes its handshake in the same cycle.
                if (req_edge) begin
                    err_overrun_nxt = 1'b1;
                end
                if (out_valid && out_ready) begin
                    out_valid_nxt = 1'b0;
                    ack_tog_nxt   = ~ack_tog;
                    state_nxt     = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_toggle_handshake_rx.sv
// Self-checking bench for toggle_handshake_rx: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_toggle_handshake_rx;

    localparam int DW = 8;
    localparam int NS = 2;
    localparam int CW = 2;

    logic          clk;
    logic          rst;
    logic          req_tog;
    logic [DW-1:0] data_in;
    logic          ack_tog;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          pulse;
    logic [CW-1:0] evt_cnt;
    logic          err_overrun;

    toggle_handshake_rx #(
        .DATA_W      (DW),
        .SYNC_STAGES (NS),
        .CNT_W       (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_tog     (req_tog),
        .data_in     (data_in),
        .ack_tog     (ack_tog),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .pulse       (pulse),
        .evt_cnt     (evt_cnt),
        .err_overrun (err_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The receiver sees the request level NS edges late; a transfer is
    // recognised when two consecutive delayed samples differ.
    logic          hist [0:NS];   // hist[i] = req_tog sampled i+1 edges ago
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic          m_ack   = 1'b0;
    logic          m_pulse = 1'b0;
    int            m_cnt   = 0;
    logic          m_err   = 1'b0;
    int            pulse_seen = 0;
    bit            cmp_en = 1'b0;

    initial begin
        for (int i = 0; i <= NS; i++) hist[i] = 1'b0;
    end

    always @(posedge clk) begin
        if (pulse === 1'b1) pulse_seen++;
        if (rst) begin
            for (int i = 0; i <= NS; i++) hist[i] = 1'b0;
            m_valid = 1'b0;
            m_data  = '0;
            m_ack   = 1'b0;
            m_pulse = 1'b0;
            m_cnt   = 0;
            m_err   = 1'b0;
        end else begin
            logic ev;
            ev = (hist[NS-1] != hist[NS]);
            for (int i = NS; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = req_tog;
            m_pulse = 1'b0;
            if (!m_valid) begin
                if (ev) begin
                    m_valid = 1'b1;
                    m_data  = data_in;
                    m_pulse = 1'b1;
                    m_cnt   = (m_cnt + 1) % (1 << CW);
                end
            end else begin
                if (ev) m_err = 1'b1;
                if (out_ready) begin
                    m_valid = 1'b0;
                    m_ack   = ~m_ack;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_out_valid",   32'(out_valid),   32'(m_valid));
            chk("m_out_data",    32'(out_data),    32'(m_data));
            chk("m_ack_tog",     32'(ack_tog),     32'(m_ack));
            chk("m_pulse",       32'(pulse),       32'(m_pulse));
            chk("m_evt_cnt",     32'(evt_cnt),     32'(m_cnt));
            chk("m_err_overrun", 32'(err_overrun), 32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst     = 1'b1;
        req_tog = 1'b0;
        step(n);
        rst     = 1'b0;
    endtask

    initial begin
        int p0;
        logic [CW-1:0] wrap_exp [0:4];

        rst       = 1'b1;
        req_tog   = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;

        // Reset then idle
        step(1);
        cmp_en = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        chk("rst_valid", 32'(out_valid),   32'd0);
        chk("rst_data",  32'(out_data),    32'd0);
        chk("rst_ack",   32'(ack_tog),     32'd0);
        chk("rst_cnt",   32'(evt_cnt),     32'd0);
        chk("rst_err",   32'(err_overrun), 32'd0);
        p0 = pulse_seen;
        step(20);
        chk("idle_pulses", 32'(pulse_seen - p0), 32'd0);
        chk("idle_valid",  32'(out_valid),       32'd0);

        // Single transfer with consumer ready
        data_in   = 8'hA5;
        req_tog   = 1'b1;
        out_ready = 1'b1;
        step(1);
        chk("single_k_pulse",  32'(pulse),     32'd0);
        step(1);
        chk("single_k1_valid", 32'(out_valid), 32'd0);
        step(1);
        chk("single_pulse",    32'(pulse),     32'd1);
        chk("single_valid",    32'(out_valid), 32'd1);
        chk("single_data",     32'(out_data),  32'hA5);
        chk("single_cnt",      32'(evt_cnt),   32'd1);
        chk("single_ack_pre",  32'(ack_tog),   32'd0);
        step(1);
        chk("single_ack",      32'(ack_tog),   32'd1);
        chk("single_valid_lo", 32'(out_valid), 32'd0);
        chk("single_pulse_lo", 32'(pulse),     32'd0);

        // Consumer stall
        out_ready = 1'b0;
        data_in   = 8'h3C;
        req_tog   = 1'b0;
        step(3);
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data",  32'(out_data),  32'h3C);
        chk("stall_cnt",   32'(evt_cnt),   32'd2);
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("stall_hold_valid", 32'(out_valid), 32'd1);
            chk("stall_hold_data",  32'(out_data),  32'h3C);
            chk("stall_hold_ack",   32'(ack_tog),   32'd1);
        end
        out_ready = 1'b1;
        step(1);
        chk("stall_ack",   32'(ack_tog),   32'd0);
        chk("stall_done",  32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Overrun
        do_reset(2);
        step(1);
        data_in = 8'h11;
        req_tog = 1'b1;
        p0 = pulse_seen;
        step(3);
        chk("ovr_data1", 32'(out_data),    32'h11);
        chk("ovr_cnt1",  32'(evt_cnt),     32'd1);
        chk("ovr_err0",  32'(err_overrun), 32'd0);
        data_in = 8'h22;
        req_tog = 1'b0;
        step(5);
        chk("ovr_err",    32'(err_overrun),     32'd1);
        chk("ovr_data",   32'(out_data),        32'h11);
        chk("ovr_cnt",    32'(evt_cnt),         32'd1);
        chk("ovr_pulses", 32'(pulse_seen - p0), 32'd1);
        out_ready = 1'b1;
        step(1);
        chk("ovr_valid_lo", 32'(out_valid),   32'd0);
        chk("ovr_ack",      32'(ack_tog),     32'd1);
        chk("ovr_err_stky", 32'(err_overrun), 32'd1);

        // Counter wrap, then reset while holding
        do_reset(2);
        step(1);
        chk("wrap_err_clr", 32'(err_overrun), 32'd0);
        wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
        wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_tog = ~req_tog;
            data_in = DW'(i + 8'h40);
            step(3);
            chk("wrap_cnt", 32'(evt_cnt), 32'(wrap_exp[i]));
            step(2);
        end
        chk("wrap_ack", 32'(ack_tog), 32'd1);
        out_ready = 1'b0;
        req_tog   = ~req_tog;
        step(3);
        chk("hold_valid", 32'(out_valid), 32'd1);
        rst     = 1'b1;
        req_tog = 1'b0;
        step(1);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_ack",   32'(ack_tog),   32'd0);
        chk("midrst_cnt",   32'(evt_cnt),   32'd0);
        rst = 1'b0;
        step(1);

        // Randomized traffic, checked every cycle by the model comparator
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(299) == 0) begin
                rst     = 1'b1;
                req_tog = 1'b0;
            end else begin
                rst = 1'b0;
                if ($urandom_range(4) == 0) begin
                    req_tog = ~req_tog;
                    data_in = DW'($urandom);
                end
            end
            out_ready = 1'($urandom_range(1));
            step(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
